lfsr_prbs_gen: RTL and testbench

//  Parametrised Fibonacci LFSR PRBS source for the transmit test path.
//  - Steps once per sam_clk_ena and emits an OUT_BITS-wide symbol each step.
//  - Supports a runtime seed load.
//  - Measures the sequence period and flags every wrap back to the seed.
//  - Feeds the symbol mapper. Period outputs give the bench/SignalTap a direct maximal-length check.

---
 rtl/lfsr_prbs_gen_if.sv | 29 ++
 rtl/lfsr_prbs_gen.sv | 81 ++++++++
 tb/tb_lfsr_prbs_gen.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/lfsr_prbs_gen_if.sv
// Control and observation bundle for the PRBS generator: step/seed requests in,
// symbol stream and period measurement out.
interface lfsr_prbs_gen_if #(
   parameter int WIDTH    = 22,
   parameter int OUT_BITS = 2
);
   logic                i_sam_clk_ena;
   logic                i_load_seed;
   logic [WIDTH-1:0]    i_seed_in;
   logic [WIDTH-1:0]    o_q;
   logic [OUT_BITS-1:0] o_sym_out;
   logic                o_sym_valid;
   logic [WIDTH-1:0]    o_step_count;
   logic                o_period_done;
   logic [WIDTH-1:0]    o_period_len;
   logic                o_period_valid;

   modport master (
      output i_sam_clk_ena, i_load_seed, i_seed_in,
      input  o_q, o_sym_out, o_sym_valid, o_step_count,
             o_period_done, o_period_len, o_period_valid
   );

   modport slave (
      input  i_sam_clk_ena, i_load_seed, i_seed_in,
      output o_q, o_sym_out, o_sym_valid, o_step_count,
             o_period_done, o_period_len, o_period_valid
   );
endinterface

// File: rtl/lfsr_prbs_gen.sv
// Fibonacci LFSR PRBS source with runtime seed load and on-line measurement of
// the sequence period (steps taken until the state returns to the seed).
module lfsr_prbs_gen #(
   parameter int               WIDTH    = 22,
   parameter logic [WIDTH-1:0] TAPS     = 22'h270000,
   parameter logic [WIDTH-1:0] SEED     = 22'h0FFFFF,
   parameter int               OUT_BITS = 2
) (
   input logic           i_clk,
   input logic           i_rst,
   lfsr_prbs_gen_if.slave bus
);

   logic [WIDTH-1:0]    r_q;
   logic [WIDTH-1:0]    r_seed;
   logic [WIDTH-1:0]    r_stepCount;
   logic [WIDTH-1:0]    r_periodLen;
   logic [OUT_BITS-1:0] r_symOut;
   logic                r_symValid;
   logic                r_periodDone;
   logic                r_periodValid;

   logic                w_fb;
   logic [WIDTH-1:0]    w_next;
   logic [WIDTH-1:0]    w_loadVal;

   assign w_fb      = ^(r_q & TAPS);
   assign w_next    = {r_q[WIDTH-2:0], w_fb};
   assign w_loadVal = (bus.i_seed_in == '0) ? SEED : bus.i_seed_in;

   // A zero state would lock the register, so it is recovered to SEED on the next step.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_q           <= SEED;
         r_seed        <= SEED;
         r_stepCount   <= '0;
         r_periodLen   <= '0;
         r_symOut      <= '0;
         r_symValid    <= 1'b0;
         r_periodDone  <= 1'b0;
         r_periodValid <= 1'b0;
      end else begin
         r_symValid   <= 1'b0;
         r_periodDone <= 1'b0;
         if (bus.i_load_seed) begin
            r_seed        <= w_loadVal;
            r_q           <= w_loadVal;
            r_stepCount   <= '0;
            r_periodValid <= 1'b0;
         end else if (bus.i_sam_clk_ena) begin
            r_symOut   <= r_q[OUT_BITS-1:0];
            r_symValid <= 1'b1;
            if (r_q == '0) begin
               r_q           <= SEED;
               r_seed        <= SEED;
               r_stepCount   <= '0;
               r_periodValid <= 1'b0;
            end else begin
               r_q <= w_next;
               if (w_next == r_seed) begin
                  r_periodLen   <= r_stepCount + WIDTH'(1);
                  r_stepCount   <= '0;
                  r_periodDone  <= 1'b1;
                  r_periodValid <= 1'b1;
               end else begin
                  r_stepCount <= r_stepCount + WIDTH'(1);
               end
            end
         end
      end
   end

   assign bus.o_q            = r_q;
   assign bus.o_sym_out      = r_symOut;
   assign bus.o_sym_valid    = r_symValid;
   assign bus.o_step_count   = r_stepCount;
   assign bus.o_period_done  = r_periodDone;
   assign bus.o_period_len   = r_periodLen;
   assign bus.o_period_valid = r_periodValid;

endmodule

// File: tb/tb_lfsr_prbs_gen.sv
// Bench for lfsr_prbs_gen: a 4-bit instance walked through a vector table and a
// default-width instance checked against a reference shift model.
module tb_lfsr_prbs_gen;

   logic clk = 1'b0;
   logic rst = 1'b0;

   int compareCount  = 0;
   int mismatchCount = 0;

   lfsr_prbs_gen_if #(.WIDTH(4),  .OUT_BITS(2)) smallBus ();
   lfsr_prbs_gen_if #(.WIDTH(22), .OUT_BITS(2)) bigBus ();

   lfsr_prbs_gen #(.WIDTH(4), .TAPS(4'hC), .SEED(4'h9), .OUT_BITS(2)) dutSmall (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (smallBus.slave)
   );

   lfsr_prbs_gen dutBig (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bigBus.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       ena;
      logic       load;
      logic [3:0] seed;
      logic [3:0] expQ;
      logic       expSymValid;
      logic [1:0] expSym;
      logic [3:0] expStep;
      logic       expDone;
      logic       expPvalid;
      logic [3:0] expLen;
   } vec_t;

   typedef struct {
      logic [21:0] q;
      logic [1:0]  sym;
      logic [21:0] step;
   } bigExp_t;

   vec_t    table_v [23];
   vec_t    smallQueue [$];
   bigExp_t bigQueue [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compareCount++;
      if (act !== exp) begin
         mismatchCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic ena, input logic load, input logic [3:0] seed,
                               input logic [3:0] q, input logic sv, input logic [1:0] sym,
                               input logic [3:0] step, input logic done, input logic pv,
                               input logic [3:0] len);
      vec_t v;
      v.ena = ena; v.load = load; v.seed = seed; v.expQ = q; v.expSymValid = sv;
      v.expSym = sym; v.expStep = step; v.expDone = done; v.expPvalid = pv; v.expLen = len;
      return v;
   endfunction

   // Pops the oldest expectation and compares it with what the small DUT shows now.
   task automatic checkOutput(input int idx);
      vec_t e;
      string tag;
      if (smallQueue.size() == 0) begin
         check("scoreboard_empty", 32'd1, 32'd0);
         return;
      end
      e = smallQueue.pop_front();
      tag = $sformatf("vec%0d", idx);
      check({tag, "_q"},      32'(smallBus.o_q),            32'(e.expQ));
      check({tag, "_symv"},   32'(smallBus.o_sym_valid),    32'(e.expSymValid));
      if (e.expSymValid) check({tag, "_sym"}, 32'(smallBus.o_sym_out), 32'(e.expSym));
      check({tag, "_step"},   32'(smallBus.o_step_count),   32'(e.expStep));
      check({tag, "_done"},   32'(smallBus.o_period_done),  32'(e.expDone));
      check({tag, "_pvalid"}, 32'(smallBus.o_period_valid), 32'(e.expPvalid));
      check({tag, "_plen"},   32'(smallBus.o_period_len),   32'(e.expLen));
   endtask

   task automatic applyStimulus(input vec_t v);
      @(negedge clk);
      smallBus.i_sam_clk_ena = v.ena;
      smallBus.i_load_seed   = v.load;
      smallBus.i_seed_in     = v.seed;
      smallQueue.push_back(v);
      @(posedge clk);
      #1;
      smallBus.i_sam_clk_ena = 1'b0;
      smallBus.i_load_seed   = 1'b0;
   endtask

   function automatic logic [21:0] bigStep(input logic [21:0] s);
      return {s[20:0], ^(s & 22'h270000)};
   endfunction

   initial begin
      logic [3:0]  seqArr [16];
      logic [21:0] mq;
      logic [21:0] mstep;
      bigExp_t     be;

      smallBus.i_sam_clk_ena = 1'b0;
      smallBus.i_load_seed   = 1'b0;
      smallBus.i_seed_in     = '0;
      bigBus.i_sam_clk_ena   = 1'b0;
      bigBus.i_load_seed     = 1'b0;
      bigBus.i_seed_in       = '0;

      seqArr = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
                 4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h1};
      table_v[0] = mk(1'b0, 1'b1, 4'h1, 4'h1, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 4'd0);
      for (int k = 1; k <= 15; k++) begin
         table_v[k] = mk(1'b1, 1'b0, 4'h0, seqArr[k], 1'b1, seqArr[k-1][1:0],
                         (k == 15) ? 4'd0 : 4'(k), (k == 15), (k == 15),
                         (k == 15) ? 4'd15 : 4'd0);
      end
      table_v[16] = mk(1'b0, 1'b0, 4'h0, 4'h1, 1'b0, 2'd0, 4'd0, 1'b0, 1'b1, 4'd15);
      table_v[17] = mk(1'b1, 1'b1, 4'h6, 4'h6, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 4'd15);
      table_v[18] = mk(1'b1, 1'b0, 4'h0, 4'hD, 1'b1, 2'd2, 4'd1, 1'b0, 1'b0, 4'd15);
      table_v[19] = mk(1'b1, 1'b0, 4'h0, 4'hA, 1'b1, 2'd1, 4'd2, 1'b0, 1'b0, 4'd15);
      table_v[20] = mk(1'b0, 1'b1, 4'h0, 4'h9, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 4'd15);
      table_v[21] = mk(1'b1, 1'b0, 4'h0, 4'h3, 1'b1, 2'd1, 4'd1, 1'b0, 1'b0, 4'd15);
      table_v[22] = mk(1'b1, 1'b0, 4'h0, 4'h6, 1'b1, 2'd3, 4'd2, 1'b0, 1'b0, 4'd15);

      // Reset takes effect before the first clock edge.
      #2 rst = 1'b1;
      #1;
      check("rst_small_q",      32'(smallBus.o_q),            32'h9);
      check("rst_small_symv",   32'(smallBus.o_sym_valid),    32'd0);
      check("rst_small_pvalid", 32'(smallBus.o_period_valid), 32'd0);
      check("rst_big_q",        32'(bigBus.o_q),              32'h0FFFFF);
      check("rst_big_plen",     32'(bigBus.o_period_len),     32'd0);
      @(negedge clk);
      rst = 1'b0;

      $display("[TB] vector table on 4-bit instance");
      for (int i = 0; i < 23; i++) begin
         applyStimulus(table_v[i]);
         checkOutput(i);
      end

      // Corrupt the state to zero and expect recovery to SEED on the next enable.
      @(negedge clk);
      force dutSmall.r_q = 4'h0;
      #1;
      release dutSmall.r_q;
      applyStimulus(mk(1'b1, 1'b0, 4'h0, 4'h9, 1'b1, 2'd0, 4'd0, 1'b0, 1'b0, 4'd15));
      checkOutput(100);
      applyStimulus(mk(1'b1, 1'b0, 4'h0, 4'h3, 1'b1, 2'd1, 4'd1, 1'b0, 1'b0, 4'd15));
      checkOutput(101);

      $display("[TB] spaced enables on default instance");
      mq    = 22'h0FFFFF;
      mstep = '0;
      for (int n = 0; n < 8; n++) begin
         @(negedge clk);
         bigBus.i_sam_clk_ena = 1'b1;
         be.sym  = mq[1:0];
         mq      = bigStep(mq);
         mstep   = mstep + 22'd1;
         be.q    = mq;
         be.step = mstep;
         bigQueue.push_back(be);
         @(posedge clk);
         #1;
         bigBus.i_sam_clk_ena = 1'b0;
         be = bigQueue.pop_front();
         check($sformatf("big%0d_symv", n), 32'(bigBus.o_sym_valid),  32'd1);
         check($sformatf("big%0d_sym", n),  32'(bigBus.o_sym_out),    32'(be.sym));
         check($sformatf("big%0d_q", n),    32'(bigBus.o_q),          32'(be.q));
         check($sformatf("big%0d_step", n), 32'(bigBus.o_step_count), 32'(be.step));
         for (int g = 0; g < 3; g++) begin
            @(posedge clk);
            #1;
            check($sformatf("big%0d_gap%0d_symv", n, g), 32'(bigBus.o_sym_valid), 32'd0);
            check($sformatf("big%0d_gap%0d_q", n, g),    32'(bigBus.o_q),         32'(mq));
         end
      end

      // Reset in the cycle right after a step, while sym_valid is still high.
      @(negedge clk);
      bigBus.i_sam_clk_ena = 1'b1;
      @(posedge clk);
      #1;
      bigBus.i_sam_clk_ena = 1'b0;
      check("midrst_pre_symv", 32'(bigBus.o_sym_valid), 32'd1);
      #1 rst = 1'b1;
      #1;
      check("midrst_big_q",      32'(bigBus.o_q),              32'h0FFFFF);
      check("midrst_big_step",   32'(bigBus.o_step_count),     32'd0);
      check("midrst_big_sym",    32'(bigBus.o_sym_out),        32'd0);
      check("midrst_big_symv",   32'(bigBus.o_sym_valid),      32'd0);
      check("midrst_big_done",   32'(bigBus.o_period_done),    32'd0);
      check("midrst_big_pvalid", 32'(bigBus.o_period_valid),   32'd0);
      check("midrst_small_q",    32'(smallBus.o_q),            32'h9);
      check("midrst_small_plen", 32'(smallBus.o_period_len),   32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(posedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule
